// File: rtl/imem_port_arbiter_if.sv
// Bundle of the fetch port, loader port and byte-wide memory port
// that surround the instruction-memory arbiter.
interface imem_port_arbiter_if;
  // Fetch (read) port
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_ack;
  logic [31:0] f_data;
  logic        f_err;
  // Loader (write) port
  logic        l_req;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_ack;
  logic        l_err;
  // Byte-wide instruction memory port
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  // Status
  logic        busy;

  // Arbiter side
  modport slave (
    input  f_req, f_addr, l_req, l_addr, l_wdata, mem_rdata,
    output f_ack, f_data, f_err, l_ack, l_err,
    output mem_addr, mem_we, mem_wdata, busy
  );

  // Requester / memory side
  modport master (
    output f_req, f_addr, l_req, l_addr, l_wdata, mem_rdata,
    input  f_ack, f_data, f_err, l_ack, l_err,
    input  mem_addr, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Round-robin arbiter between an instruction-fetch reader and a program
// loader sharing a byte-wide instruction memory. Each word access takes
// four byte beats (little-endian); illegal addresses are answered with an
// error acknowledge and never touch the memory.
module imem_port_arbiter #(
  parameter int unsigned MEM_BYTES = 32
) (
  input  logic                clk,
  input  logic                reset,
  imem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  // Highest legal word base address.
  localparam logic [31:0] LAST_OK = 32'(MEM_BYTES - 4);

  state_t      r_state;
  logic [1:0]  r_beat;
  logic [31:0] r_base;
  logic [31:0] r_wdata;
  logic [23:0] r_rdbuf;
  logic [31:0] r_f_data;
  logic        r_f_ack;
  logic        r_f_err;
  logic        r_l_ack;
  logic        r_l_err;
  logic        r_last_fetch;  // 1 when the fetch port won the last grant

  logic        w_grant_fetch;
  logic        w_any_req;
  logic [31:0] w_sel_addr;
  logic        w_illegal;
  logic [31:0] w_mem_addr;
  logic        w_mem_we;
  logic [7:0]  w_mem_wdata;

  // Grant selection: a tie goes to whichever port did not win last time.
  always_comb begin
    w_any_req     = bus.f_req | bus.l_req;
    w_grant_fetch = bus.f_req & (~bus.l_req | ~r_last_fetch);
    w_sel_addr    = w_grant_fetch ? bus.f_addr : bus.l_addr;
    w_illegal     = (w_sel_addr[1:0] != 2'b00) || (w_sel_addr > LAST_OK);
  end

  // Single FSM: arbitration, byte beats and registered acknowledge outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_beat       <= 2'd0;
      r_base       <= 32'd0;
      r_wdata      <= 32'd0;
      r_rdbuf      <= 24'd0;
      r_f_data     <= 32'd0;
      r_f_ack      <= 1'b0;
      r_f_err      <= 1'b0;
      r_l_ack      <= 1'b0;
      r_l_err      <= 1'b0;
      r_last_fetch <= 1'b1;
    end else begin
      // Acks and errors are single-cycle pulses raised on entry to RESP.
      r_f_ack <= 1'b0;
      r_f_err <= 1'b0;
      r_l_ack <= 1'b0;
      r_l_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_last_fetch <= w_grant_fetch;
            r_base       <= w_sel_addr;
            r_beat       <= 2'd0;
            if (!w_grant_fetch) begin
              r_wdata <= bus.l_wdata;
            end
            if (w_illegal) begin
              r_state <= RESP;
              r_f_ack <= w_grant_fetch;
              r_f_err <= w_grant_fetch;
              r_l_ack <= ~w_grant_fetch;
              r_l_err <= ~w_grant_fetch;
              if (w_grant_fetch) begin
                r_f_data <= 32'd0;
              end
            end else begin
              r_state <= w_grant_fetch ? RD : WR;
            end
          end
        end
        RD: begin
          r_beat <= r_beat + 2'd1;
          case (r_beat)
            2'd0: r_rdbuf[7:0]   <= bus.mem_rdata;
            2'd1: r_rdbuf[15:8]  <= bus.mem_rdata;
            2'd2: r_rdbuf[23:16] <= bus.mem_rdata;
            default: begin
              // Last beat goes straight into the output word.
              r_f_data <= {bus.mem_rdata, r_rdbuf};
              r_f_ack  <= 1'b1;
              r_state  <= RESP;
            end
          endcase
        end
        WR: begin
          r_beat <= r_beat + 2'd1;
          if (r_beat == 2'd3) begin
            r_l_ack <= 1'b1;
            r_state <= RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Memory port drive; the write strobe is gated by reset so an abandoned
  // write never lands the byte of the beat in which reset arrives.
  always_comb begin
    w_mem_addr  = 32'd0;
    w_mem_we    = 1'b0;
    w_mem_wdata = 8'd0;
    if (r_state == RD || r_state == WR) begin
      w_mem_addr = r_base + {30'd0, r_beat};
    end
    if (r_state == WR) begin
      w_mem_we = ~reset;
      case (r_beat)
        2'd0:    w_mem_wdata = r_wdata[7:0];
        2'd1:    w_mem_wdata = r_wdata[15:8];
        2'd2:    w_mem_wdata = r_wdata[23:16];
        default: w_mem_wdata = r_wdata[31:24];
      endcase
    end
  end

  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.f_ack     = r_f_ack;
  assign bus.f_err     = r_f_err;
  assign bus.f_data    = r_f_data;
  assign bus.l_ack     = r_l_ack;
  assign bus.l_err     = r_l_err;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: a byte memory model, a
// scoreboard of expected acknowledges, and one task per scenario.
module tb_imem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_port_arbiter_if bus();

  imem_port_arbiter #(.MEM_BYTES(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Attached memory and the bench's own expectation of its contents.
  logic [7:0] mem   [0:31];
  logic [7:0] model [0:31];

  assign bus.mem_rdata = mem[bus.mem_addr[4:0]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[4:0]] <= bus.mem_wdata;

  typedef struct {
    bit          is_fetch;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Scoreboard: every acknowledge pops the oldest expected response.
  always @(negedge clk) begin
    if (reset === 1'b0 && (bus.f_ack === 1'b1 || bus.l_ack === 1'b1)) begin
      exp_t e;
      $display("txn ack f_ack=%0b l_ack=%0b f_data=%h f_err=%0b l_err=%0b",
               bus.f_ack, bus.l_ack, bus.f_data, bus.f_err, bus.l_err);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_ack f_ack=%0b l_ack=%0b required no ack", bus.f_ack, bus.l_ack);
      end else begin
        e = sb.pop_front();
        if ({bus.f_ack, bus.l_ack} !== {e.is_fetch, ~e.is_fetch}) begin
          errors++;
          $display("FAIL sb_ack_port f_ack/l_ack=%b%b required %b%b",
                   bus.f_ack, bus.l_ack, e.is_fetch, ~e.is_fetch);
        end else if (e.is_fetch) begin
          checks++;
          if (bus.f_data !== e.data || bus.f_err !== e.err) begin
            errors++;
            $display("FAIL sb_fetch data=%h err=%0b required data=%h err=%0b",
                     bus.f_data, bus.f_err, e.data, e.err);
          end
        end else begin
          checks++;
          if (bus.l_err !== e.err) begin
            errors++;
            $display("FAIL sb_load err=%0b required %0b", bus.l_err, e.err);
          end
        end
      end
    end
  end

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int idx;
    idx = int'(a[4:0]);
    return {model[idx+3], model[idx+2], model[idx+1], model[idx]};
  endfunction

  task automatic do_fetch(input logic [31:0] a, input int exp_lat, input bit exp_err);
    exp_t e;
    int   n;
    int   we_cnt;
    bit   got;
    @(negedge clk);
    e.is_fetch = 1'b1;
    e.err      = exp_err;
    e.data     = exp_err ? 32'd0 : model_word(a);
    sb.push_back(e);
    bus.f_addr = a;
    bus.f_req  = 1'b1;
    n = 0; we_cnt = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.mem_we === 1'b1) we_cnt++;
      if (bus.f_ack === 1'b1) got = 1'b1;
    end
    bus.f_req = 1'b0;
    checks++;
    if (!got || n !== exp_lat) begin
      errors++;
      $display("FAIL fetch_latency addr=%h cycles=%0d required %0d", a, got ? n : -1, exp_lat);
    end
    checks++;
    if (we_cnt !== 0) begin
      errors++;
      $display("FAIL fetch_no_write addr=%h mem_we_cycles=%0d required 0", a, we_cnt);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input int exp_lat, input bit exp_err);
    exp_t e;
    int   n;
    int   we_cnt;
    bit   got;
    @(negedge clk);
    e.is_fetch = 1'b0;
    e.err      = exp_err;
    e.data     = 32'd0;
    sb.push_back(e);
    if (!exp_err) begin
      for (int i = 0; i < 4; i++) model[int'(a[4:0]) + i] = d[8*i +: 8];
    end
    bus.l_addr  = a;
    bus.l_wdata = d;
    bus.l_req   = 1'b1;
    n = 0; we_cnt = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.mem_we === 1'b1) we_cnt++;
      if (bus.l_ack === 1'b1) got = 1'b1;
    end
    bus.l_req = 1'b0;
    checks++;
    if (!got || n !== exp_lat) begin
      errors++;
      $display("FAIL write_latency addr=%h cycles=%0d required %0d", a, got ? n : -1, exp_lat);
    end
    checks++;
    if (we_cnt !== (exp_err ? 0 : 4)) begin
      errors++;
      $display("FAIL write_strobes addr=%h mem_we_cycles=%0d required %0d", a, we_cnt, exp_err ? 0 : 4);
    end
  endtask

  task automatic check_mem(input int lo, input int hi, input string tag);
    for (int i = lo; i <= hi; i++) begin
      checks++;
      if (mem[i] !== model[i]) begin
        errors++;
        $display("FAIL %s mem[%0d]=%h required %h", tag, i, mem[i], model[i]);
      end
    end
  endtask

  // Reset wins over requests present in the same cycles; outputs all quiet.
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.f_req = 1'b1; bus.f_addr = 32'd0;
    bus.l_req = 1'b1; bus.l_addr = 32'd4; bus.l_wdata = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.f_ack, bus.l_ack, bus.f_err, bus.l_err, bus.mem_we, bus.f_data} !== 38'd0) begin
      errors++;
      $display("FAIL reset_outputs busy=%0b f_ack=%0b l_ack=%0b f_err=%0b l_err=%0b mem_we=%0b f_data=%h required all 0",
               bus.busy, bus.f_ack, bus.l_ack, bus.f_err, bus.l_err, bus.mem_we, bus.f_data);
    end
    bus.f_req = 1'b0; bus.l_req = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%0b required 0", bus.busy);
    end
  endtask

  // Word fetch from 0: byte addresses 0..3 in consecutive cycles, ack on the fifth.
  task automatic test_fetch();
    exp_t e;
    @(negedge clk);
    e.is_fetch = 1'b1; e.err = 1'b0; e.data = 32'h00708093;
    sb.push_back(e);
    bus.f_addr = 32'd0;
    bus.f_req  = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_addr !== 32'(n - 1) || bus.mem_we !== 1'b0 || bus.f_ack !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL fetch_beat%0d mem_addr=%h mem_we=%0b f_ack=%0b busy=%0b required addr=%h we=0 ack=0 busy=1",
                 n - 1, bus.mem_addr, bus.mem_we, bus.f_ack, bus.busy, 32'(n - 1));
      end
    end
    @(negedge clk);
    checks++;
    if (bus.f_ack !== 1'b1 || bus.mem_addr !== 32'd0) begin
      errors++;
      $display("FAIL fetch_resp f_ack=%0b mem_addr=%h required ack=1 addr=0", bus.f_ack, bus.mem_addr);
    end
    bus.f_req = 1'b0;
  endtask

  // Loader write then read-back; f_data holds its value across the write.
  task automatic test_write();
    do_write(32'd12, 32'h40208233, 5, 1'b0);
    check_mem(12, 15, "write_bytes");
    checks++;
    if (bus.f_data !== 32'h00708093) begin
      errors++;
      $display("FAIL fdata_hold f_data=%h required 00708093", bus.f_data);
    end
    do_fetch(32'd12, 5, 1'b0);
  endtask

  // Highest legal word and the illegal neighbours around the edges.
  task automatic test_boundary();
    do_write(32'd28, $urandom, 5, 1'b0);
    check_mem(28, 31, "boundary_bytes");
    do_fetch(32'd28, 5, 1'b0);
    do_fetch(32'd2, 1, 1'b1);
    do_write(32'd32, 32'h11223344, 1, 1'b1);
    do_fetch(32'hFFFF_FFFC, 1, 1'b1);
    do_write(32'd5, 32'h55667788, 1, 1'b1);
    check_mem(0, 31, "illegal_untouched");
  endtask

  // Tie straight after reset goes to the loader, then grants alternate while both hold.
  task automatic test_tie();
    exp_t e;
    int   acks;
    int   ack_cyc[4];
    int   want[4];
    logic [31:0] d;
    d = 32'hC0FFEE01;
    want[0] = 5; want[1] = 11; want[2] = 17; want[3] = 23;
    for (int i = 0; i < 4; i++) ack_cyc[i] = -1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) model[16 + i] = d[8*i +: 8];
    for (int i = 0; i < 4; i++) begin
      e.is_fetch = (i % 2) == 1;
      e.err      = 1'b0;
      e.data     = d;
      sb.push_back(e);
    end
    bus.f_addr = 32'd16; bus.l_addr = 32'd16; bus.l_wdata = d;
    bus.f_req = 1'b1; bus.l_req = 1'b1;
    acks = 0;
    for (int n = 1; n <= 40 && acks < 4; n++) begin
      @(negedge clk);
      if (bus.f_ack === 1'b1 || bus.l_ack === 1'b1) begin
        ack_cyc[acks] = n;
        acks++;
      end
    end
    bus.f_req = 1'b0; bus.l_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ack_cyc[i] !== want[i]) begin
        errors++;
        $display("FAIL tie_ack%0d cycle=%0d required %0d", i, ack_cyc[i], want[i]);
      end
    end
  endtask

  // Reset during beat 2 of a write: no ack, first two bytes landed, rest untouched.
  task automatic test_reset_midwrite();
    @(negedge clk);
    bus.l_addr = 32'd0; bus.l_wdata = 32'hAABBCCDD; bus.l_req = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bus.l_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.l_ack !== 1'b0) begin
      errors++;
      $display("FAIL midwrite_reset busy=%0b l_ack=%0b required 0 0", bus.busy, bus.l_ack);
    end
    reset = 1'b0;
    model[0] = 8'hDD;
    model[1] = 8'hCC;
    check_mem(0, 3, "midwrite_bytes");
    repeat (8) @(negedge clk);
    do_fetch(32'd0, 5, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    bus.f_req = 1'b0; bus.f_addr = 32'd0;
    bus.l_req = 1'b0; bus.l_addr = 32'd0; bus.l_wdata = 32'd0;
    for (int i = 0; i < 32; i++) begin
      mem[i]   = 8'($urandom);
      model[i] = mem[i];
    end
    mem[0] = 8'h93; mem[1] = 8'h80; mem[2] = 8'h70; mem[3] = 8'h00;
    for (int i = 0; i < 4; i++) model[i] = mem[i];

    test_reset();
    test_fetch();
    test_write();
    test_boundary();
    test_tie();
    test_reset_midwrite();

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL sb_drain pending=%0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

Interface
REQ-001 The module SHALL have one parameter: MEM_BYTES, default 32, the byte capacity of the attached instruction memory (power of two, minimum 4).
REQ-002 The module SHALL have these ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- f_req  input  1  fetch read request; held high until f_ack.
- f_addr  input  32  fetch byte address.
- f_ack  output  1  one-cycle fetch completion pulse.
- f_data  output  32  fetched word; valid while f_ack is high.
- f_err  output  1  fetch error; valid while f_ack is high.
- l_req  input  1  loader write request; held high until l_ack.
- l_addr  input  32  loader byte address.
- l_wdata  input  32  loader word to write.
- l_ack  output  1  one-cycle loader completion pulse.
- l_err  output  1  loader error; valid while l_ack is high.
- mem_addr  output  32  byte address to the memory.
- mem_we  output  1  byte write enable.
- mem_wdata  output  8  write byte.
- mem_rdata  input  8  read byte; combinational from mem_addr in the same cycle.
- busy  output  1  high in every state except IDLE.

Function
REQ-003 The FSM SHALL have four states: IDLE, RD, WR and RESP.
REQ-004 In IDLE, when only one request is high, the module SHALL grant that requester.
REQ-005 In IDLE, when both requests are high, the module SHALL grant the requester not granted most recently (round-robin).
REQ-006 After reset, the first tie SHALL go to the loader; the last-granted register resets to "fetch".
REQ-007 On a grant, the module SHALL latch the address (and write data for the loader) and clear the 2-bit beat counter.
REQ-008 On a grant, the next state SHALL be RD for fetch, WR for loader, or RESP with error when the request is illegal.
REQ-009 A request SHALL be illegal when addr[1:0] != 0 or addr > MEM_BYTES-4.
REQ-010 An illegal request SHALL cause no memory access; f_data SHALL be 0 during its acknowledge.
REQ-011 In RD, the module SHALL drive mem_addr = base + beat and capture mem_rdata into f_data byte lane [8*beat+7:8*beat].
- Byte order is little-endian: the byte at base is the LSB.
REQ-012 In WR, the module SHALL drive mem_addr = base + beat, mem_we = 1 and mem_wdata = l_wdata byte lane beat.
REQ-013 The beat counter SHALL increment once per cycle in RD and WR; after beat 3 the FSM SHALL go to RESP.
REQ-014 RESP SHALL last exactly one cycle and assert the granted requester's ack (with its err flag); the next state SHALL be IDLE.
REQ-015 Latency, with the grant edge as edge k:
- legal access: ack high in the cycle after edge k+4 (five cycles from grant);
- illegal access: ack high in the cycle after edge k.
REQ-016 The module SHALL sample requests only in IDLE.
- Deassertion of a request mid-transaction SHALL not abort it; the ack is still issued.
- A request still high in the IDLE cycle after its ack SHALL start a new transaction.
REQ-017 The non-granted requester SHALL wait with no ack; its request SHALL be granted in the next IDLE cycle.
REQ-018 Outside RD and WR, the module SHALL drive mem_addr = 0, mem_we = 0 and mem_wdata = 0.
REQ-019 f_data SHALL hold its last value outside RESP.
REQ-020 Address arithmetic SHALL be 32-bit unsigned; wrap-around is impossible because out-of-range addresses are rejected (REQ-009).

Reset
REQ-021 When reset is high at a clock edge, the module SHALL set state = IDLE, beat = 0, f_ack = l_ack = 0, f_err = l_err = 0, f_data = 0, mem_we = 0, busy = 0 and last-granted = fetch.
REQ-022 Reset asserted mid-transaction SHALL abandon it with no ack.
- Bytes already written stay in memory.
- The requester SHALL re-request after reset.
REQ-023 Reset SHALL take priority over every request arriving in the same cycle.

Verification
REQ-024 Bytes 0..3 = 93,80,70,00 (hex), f_req with f_addr = 0 -> mem_addr 0,1,2,3 in four consecutive cycles, then f_ack = 1, f_data = 0x00708093, f_err = 0, five cycles after the grant.
REQ-025 l_req with l_addr = 12, l_wdata = 0x40208233 -> mem_we high for four cycles writing 33,82,20,40 to addresses 12..15, then l_ack = 1; a following fetch at 12 returns 0x40208233.
REQ-026 f_req and l_req both high in the first cycle after reset -> loader served first (l_ack), fetch served next (f_ack about six cycles later); a repeated tie alternates grants.
REQ-027 Illegal requests, one at a time with MEM_BYTES = 32:
- f_addr = 2 -> f_ack with f_err = 1, f_data = 0, mem_we never high;
- l_addr = 32 -> l_ack with l_err = 1, mem_we never high.
REQ-028 Reset asserted during WR beat 2 of a write to address 0 (l_wdata = 0xAABBCCDD) -> no l_ack; bytes 0..1 = DD,CC and bytes 2..3 unchanged; busy = 0 in the cycle after the reset edge.
